// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cooking controller:
// FSM state encoding, BCD digit type and the quick-start time helper.
package microwave_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ENTRY  = 3'd1,
      LOAD   = 3'd2,
      COOK   = 3'd3,
      PAUSED = 3'd4,
      DONE   = 3'd5
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam logic [15:0] QUICK_SECS    = 16'h0030;
   localparam bcd_t        BCD_MAX_DIGIT = 4'd9;

   // Adds 30 s to an mm:ss BCD time; seconds wrap into minutes, result clamps at 99:59.
   function automatic logic [15:0] bcd_add30(input logic [15:0] t);
      int secs;
      int mins;
      secs = int'(t[7:4]) * 10 + int'(t[3:0]) + 30;
      mins = int'(t[15:12]) * 10 + int'(t[11:8]);
      if (secs >= 60) begin
         secs = secs - 60;
         mins = mins + 1;
      end
      if (mins > 99) return 16'h9959;
      return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
   endfunction

endpackage

// File: rtl/microwave_ctrl_entry.sv
// bcd_entry_reg: NUM_DIGITS-nibble keypad shift register with clear,
// parallel load and left shift (new digit enters the lowest nibble).
import microwave_pkg::*;

module bcd_entry_reg #(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    shift,
   input  logic                    clear,
   input  logic                    pload,
   input  bcd_t                    digit,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   output logic [4*NUM_DIGITS-1:0] value
);

   localparam int W = 4 * NUM_DIGITS;

   // Clear outranks load, load outranks shift.
   always_ff @(posedge clk) begin
      if (rst || clear)
         value <= '0;
      else if (pload)
         value <= load_val;
      else if (shift)
         value <= {value[W-5:0], digit};
   end

endmodule

// File: rtl/microwave_ctrl.sv
// Cooking controller upstream of the timer_ten chain: keypad preset, load,
// count gating, magnetron and beeper. Optional feature macro: QUICK_START_EN.
import microwave_pkg::*;

module microwave_ctrl #(
   parameter int          NUM_DIGITS  = 4,
   parameter int          DONE_CYCLES = 3000,
   parameter logic [15:0] QUICK_TIME  = QUICK_SECS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    key_valid,
   input  logic [3:0]              key_digit,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    door_closed,
   input  logic                    sec_tick,
   input  logic                    timer_zero,
   output logic                    load,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic                    count_en,
   output logic                    mag_on,
   output logic                    beep,
   output logic [2:0]              state_o
);

   localparam int W     = 4 * NUM_DIGITS;
   localparam int CNT_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_CYCLES - 1);

   state_t           state, next;
   logic [CNT_W-1:0] beep_cnt;
   logic             shift, clear, pload, digit_ok, add_pulse;
   logic [W-1:0]     pload_val;

   bcd_entry_reg #(.NUM_DIGITS(NUM_DIGITS)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .shift    (shift),
      .clear    (clear),
      .pload    (pload),
      .digit    (key_digit),
      .load_val (pload_val),
      .value    (digits_out)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_ff @(posedge clk) begin
      if (rst || state != DONE)   beep_cnt <= '0;
      else if (beep_cnt != CNT_LAST) beep_cnt <= beep_cnt + 1'b1;
   end

`ifdef QUICK_START_EN
   logic add_pulse_d;
   // A time extension in COOK re-presents the updated preset to the chain next cycle.
   always_ff @(posedge clk) begin
      if (rst) add_pulse <= 1'b0;
      else     add_pulse <= add_pulse_d;
   end
`else
   assign add_pulse = 1'b0;
`endif

   assign digit_ok = key_valid && (key_digit <= BCD_MAX_DIGIT);

   // NOTE: every signal driven here gets a default first, so no path infers a latch.
   always_comb begin
      next      = state;
      shift     = 1'b0;
      clear     = 1'b0;
      pload     = 1'b0;
      pload_val = digits_out;
`ifdef QUICK_START_EN
      add_pulse_d = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (digit_ok) begin
               shift = 1'b1;
               next  = ENTRY;
            end
`ifdef QUICK_START_EN
            else if (start && door_closed) begin
               pload     = 1'b1;
               pload_val = W'(QUICK_TIME);
               next      = LOAD;
            end
`endif
         end
         ENTRY: begin
            if (stop) begin
               clear = 1'b1;
               next  = IDLE;
            end else if (start && door_closed && digits_out != '0)
               next = LOAD;
            else if (digit_ok)
               shift = 1'b1;
         end
         LOAD: next = COOK;
         COOK: begin
            if (timer_zero)        next = DONE;
            else if (stop)         next = PAUSED;
            else if (!door_closed) next = PAUSED;
`ifdef QUICK_START_EN
            else if (start) begin
               pload       = 1'b1;
               pload_val   = W'(bcd_add30(16'(digits_out)));
               add_pulse_d = 1'b1;
            end
`endif
         end
         PAUSED: begin
            if (stop) begin
               clear = 1'b1;
               next  = IDLE;
            end else if (start && door_closed)
               next = COOK;
         end
         DONE: begin
            if (stop || !door_closed || beep_cnt == CNT_LAST) begin
               clear = 1'b1;
               next  = IDLE;
            end
         end
         default: next = IDLE;
      endcase
   end

   assign load     = (state == LOAD) || add_pulse;
   assign mag_on   = (state == COOK);
   assign count_en = (state == COOK) && sec_tick;
   assign beep     = (state == DONE);
   assign state_o  = state;

endmodule
